// File: rtl/exp_term_decomposer_if.sv
// Argument/result bus of exp_term_decomposer: one request channel (x) and one
// response channel (codes, count, residual).
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both 1. A producer holding valid keeps its payload stable until that edge,
// and valid never depends combinationally on ready.
interface exp_term_decomposer_if #(
  parameter int INT_W   = 4,
  parameter int FRA_W   = 11,
  parameter int N_TERMS = 6,
  parameter int IDX_W   = 5
);
  localparam int XW    = INT_W + FRA_W;
  localparam int CW    = IDX_W + 1;
  localparam int CNT_W = $clog2(N_TERMS + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [XW-1:0]           x;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_TERMS*CW-1:0]   codes;
  logic [CNT_W-1:0]        count;
  logic [XW-1:0]           residual;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, codes, count, residual
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, codes, count, residual
  );
endinterface

// File: rtl/exp_term_decomposer.sv
// Greedy decomposition of x into one k*ln2 term followed by ln(1+2^-i) terms,
// producing packed {is_frac, idx} codes for the shift-add exponent datapath.
module exp_term_decomposer #(
  parameter int INT_W   = 4,
  parameter int FRA_W   = 11,
  parameter int N_TERMS = 6,
  parameter int IDX_W   = 5,
  parameter int LN2     = 1420,
  parameter logic [FRA_W*(INT_W+FRA_W)-1:0] LN_TABLE = {
    15'd1, 15'd2, 15'd4, 15'd8, 15'd16, 15'd32,
    15'd63, 15'd124, 15'd241, 15'd457, 15'd830}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  exp_term_decomposer_if.slave    bus,
  output logic [1:0]              dbg_state
);
  localparam int XW    = INT_W + FRA_W;
  localparam int CW    = IDX_W + 1;
  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam int K_MAX = ((1 << XW) - 1) / LN2;

  typedef enum logic [1:0] {IDLE = 2'd0, SEL = 2'd1, UPD = 2'd2, DONE = 2'd3} state_e;

  state_e                state_q, state_d;
  logic [XW-1:0]         r_q, r_d;
  logic [N_TERMS*CW-1:0] codes_q, codes_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [XW-1:0]         term_q, term_d;
  logic [CW-1:0]         code_q, code_d;

  logic [IDX_W-1:0]      k_idx, f_idx;
  logic [XW-1:0]         k_term, f_term;
  int                    r_int;

  // Candidate terms: largest k with k*LN2 <= r, smallest i with F(i) <= r.
  always_comb begin
    r_int  = int'(r_q);
    k_idx  = '0;
    k_term = '0;
    f_idx  = '0;
    f_term = '0;
    for (int k = 1; k <= K_MAX; k++) begin
      if (k * LN2 <= r_int) begin
        k_idx  = IDX_W'(k);
        k_term = XW'(k * LN2);
      end
    end
    for (int i = FRA_W; i >= 1; i--) begin
      if (int'(LN_TABLE[(i-1)*XW +: XW]) <= r_int) begin
        f_idx  = IDX_W'(i);
        f_term = LN_TABLE[(i-1)*XW +: XW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    codes_d = codes_q;
    count_d = count_q;
    term_d  = term_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          r_d     = bus.x;
          codes_d = '0;
          count_d = '0;
          state_d = SEL;
        end
      end
      SEL: begin
        if (r_q == '0) begin
          state_d = DONE;
        end else if (r_int >= LN2) begin
          term_d  = k_term;
          code_d  = {1'b0, k_idx};
          state_d = UPD;
        end else begin
          term_d  = f_term;
          code_d  = {1'b1, f_idx};
          state_d = UPD;
        end
      end
      UPD: begin
        r_d     = r_q - term_q;
        count_d = count_q + CNT_W'(1);
        for (int j = 0; j < N_TERMS; j++) begin
          if (count_q == CNT_W'(j)) codes_d[j*CW +: CW] = code_q;
        end
        if ((int'(count_q) + 1 == N_TERMS) || (r_q == term_q)) state_d = DONE;
        else                                                   state_d = SEL;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      codes_q <= '0;
      count_q <= '0;
      term_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      codes_q <= codes_d;
      count_q <= count_d;
      term_q  <= term_d;
      code_q  <= code_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.codes     = codes_q;
  assign bus.count     = count_q;
  assign bus.residual  = r_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_exp_term_decomposer.sv
// Bench for exp_term_decomposer: directed table, backpressure and reset
// sequences, then random arguments against a real-arithmetic reference model.
module tb_exp_term_decomposer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  int f_tab[1:11];
  int ln2_ref;

  exp_term_decomposer_if #(.INT_W(4), .FRA_W(11), .N_TERMS(6), .IDX_W(5)) bus ();

  exp_term_decomposer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] x;
    logic [35:0] codes;
    logic [2:0]  count;
    logic [14:0] res;
    int          lat;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Greedy decomposition from the mathematical definition: integer part by
  // division, fractional terms from a log table built with real arithmetic.
  function automatic void model(input int xv, output logic [35:0] c, output int n,
                                output int res, output int lat);
    int r;
    int code;
    r = xv;
    c = '0;
    n = 0;
    while (r > 0 && n < 6) begin
      if (r >= ln2_ref) begin
        code = r / ln2_ref;
        r    = r - code * ln2_ref;
      end else begin
        code = 0;
        for (int i = 11; i >= 1; i--) if (f_tab[i] <= r) code = 32 + i;
        r = r - f_tab[code - 32];
      end
      c[n*6 +: 6] = 6'(code);
      n++;
    end
    res = r;
    lat = (n == 0) ? 1 : 2 * n;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.out_valid) begin
      check("out_valid_timeout", 64'd0, 64'd1);
      lat = -1;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_valid_ready", {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  task automatic do_txn(input logic [14:0] xv, input int hold,
                        output logic [35:0] c, output logic [2:0] n,
                        output logic [14:0] res, output int lat);
    int t;
    c = '0; n = '0; res = '0; lat = -1;
    @(negedge clk);
    bus.x = xv;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x = 15'($urandom_range(0, 32767));
    wait_valid(lat);
    if (lat < 0) return;
    c = bus.codes;
    n = bus.count;
    res = bus.residual;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_stable", {bus.out_valid, bus.in_ready, bus.codes, bus.count, bus.residual},
            {1'b1, 1'b0, c, n, res});
    end
    release_result();
  endtask

  initial begin
    logic [35:0] c, mc;
    logic [2:0]  n;
    logic [14:0] res, xr;
    int          lat, mn, mres, mlat, t;

    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.out_ready = 1'b0;

    for (int i = 1; i <= 11; i++) f_tab[i] = $rtoi($ln(1.0 + 2.0 ** (-i)) * 2048.0 + 0.5);
    ln2_ref = $rtoi($ln(2.0) * 2048.0 + 0.5);

    tbl[0] = '{15'd2048,  {6'd41, 6'd40, 6'd38, 6'd36, 6'd34, 6'd1},  3'd6, 15'd3, 12};
    tbl[1] = '{15'd1420,  {30'd0, 6'd1},                              3'd1, 15'd0, 2};
    tbl[2] = '{15'd0,     36'd0,                                      3'd0, 15'd0, 1};
    tbl[3] = '{15'd32767, {6'd0, 6'd41, 6'd40, 6'd38, 6'd37, 6'd23},  3'd5, 15'd0, 10};
    tbl[4] = '{15'd830,   {30'd0, 6'd33},                             3'd1, 15'd0, 2};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_codes",     bus.codes,     0);
    check("rst_count",     bus.count,     0);
    check("rst_residual",  bus.residual,  0);
    rst_n = 1'b1;

    // Directed table
    for (int v = 0; v < 5; v++) begin
      do_txn(tbl[v].x, 1, c, n, res, lat);
      check("tbl_codes", c,   tbl[v].codes);
      check("tbl_count", n,   tbl[v].count);
      check("tbl_res",   res, tbl[v].res);
      check("tbl_lat",   lat, tbl[v].lat);
    end

    // Backpressure: x=830 held in DONE for 10 cycles while x=2048 waits
    @(negedge clk);
    bus.x = 15'd830;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.x = 15'd2048;
    check("bp_busy_in_ready", bus.in_ready, 0);
    wait_valid(lat);
    check("bp_lat", lat, 2);
    for (int h = 0; h < 10; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold", {bus.out_valid, bus.in_ready, bus.codes, bus.count, bus.residual},
            {1'b1, 1'b0, 30'd0, 6'd33, 3'd1, 15'd0});
    end
    release_result();
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_second_accepted", bus.in_ready, 0);
    wait_valid(lat);
    model(2048, mc, mn, mres, mlat);
    check("bp2_codes", bus.codes,    mc);
    check("bp2_count", bus.count,    mn);
    check("bp2_res",   bus.residual, mres);
    check("bp2_lat",   lat,          mlat);
    release_result();

    // Reset pulse during UPD
    @(negedge clk);
    bus.x = 15'd2048;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    t = 0;
    while (dbg_state != 2'd2 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("reach_upd", dbg_state, 2'd2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_outputs",
          {bus.in_ready, bus.out_valid, bus.codes, bus.count, bus.residual}, {2'b10, 54'd0});
    rst_n = 1'b1;
    do_txn(15'd1420, 0, c, n, res, lat);
    check("post_rst_codes", c,   36'd1);
    check("post_rst_count", n,   3'd1);
    check("post_rst_res",   res, 15'd0);
    check("post_rst_lat",   lat, 2);

    // Random arguments against the reference model
    for (int v = 0; v < 60; v++) begin
      if ($urandom_range(0, 3) == 0) xr = 15'($urandom_range(0, 40));
      else                           xr = 15'($urandom_range(0, 32767));
      do_txn(xr, $urandom_range(0, 3), c, n, res, lat);
      model(int'(xr), mc, mn, mres, mlat);
      check("rnd_codes", c,   mc);
      check("rnd_count", n,   mn);
      check("rnd_res",   res, mres);
      check("rnd_lat",   lat, mlat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
